// File: rtl/screen_wr_buffer.sv
// Screen write buffer. Filters CPU memory writes down to the screen window,
// merges repeated writes to the newest word, and drains them in order to video RAM.
module screen_wr_buffer #(
    parameter int                DEPTH       = 16,
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 15,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = 'h4000,
    parameter int                SCREEN_AW   = 13,
    parameter int                DROP_W      = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       CpuWrEn,
    input  logic [ADDR_W-1:0]          CpuWrAddr,
    input  logic [DATA_W-1:0]          CpuWrData,
    output logic                       VramWrEn,
    output logic [SCREEN_AW-1:0]       VramAddr,
    output logic [DATA_W-1:0]          VramData,
    input  logic                       VramReady,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Overflow,
    output logic [DROP_W-1:0]          DropCnt,
    input  logic                       ClrOverflow
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;
    localparam logic [ADDR_W:0] WinSize = (ADDR_W+1)'(1) << SCREEN_AW;
    localparam logic [ADDR_W:0] WinEnd  = {1'b0, SCREEN_BASE} + WinSize;

    logic [DATA_W-1:0]    dataMem [DEPTH];
    logic [SCREEN_AW-1:0] addrMem [DEPTH];

    logic [PtrW-1:0]      rdPtr, wrPtr, lastPtr;
    logic [CntW-1:0]      count;
    logic                 overflow;
    logic [DROP_W-1:0]    dropCnt;

    logic                 inWindow, pop, merge, push, pushOk, drop;
    logic [SCREEN_AW-1:0] offset;

    assign inWindow = CpuWrEn && (CpuWrAddr >= SCREEN_BASE) && ({1'b0, CpuWrAddr} < WinEnd);
    // Low bits of the difference only depend on low bits of the operands.
    assign offset   = CpuWrAddr[SCREEN_AW-1:0] - SCREEN_BASE[SCREEN_AW-1:0];
    assign lastPtr  = wrPtr - PtrW'(1);

    assign VramWrEn = (count != '0);
    assign VramAddr = addrMem[rdPtr];
    assign VramData = dataMem[rdPtr];
    assign Count    = count;
    assign Full     = (count == CntW'(DEPTH));
    assign Overflow = overflow;
    assign DropCnt  = dropCnt;

    assign pop    = VramWrEn && VramReady;
    // A lone entry leaving this cycle can no longer absorb the write.
    assign merge  = inWindow && (count != '0) && (addrMem[lastPtr] == offset)
                    && !((count == CntW'(1)) && pop);
    assign push   = inWindow && !merge;
    assign pushOk = push && (!Full || pop);
    assign drop   = push && Full && !pop;

    always_ff @(posedge Clock) begin
        if (pushOk) begin
            dataMem[wrPtr] <= CpuWrData;
            addrMem[wrPtr] <= offset;
        end else if (merge) begin
            dataMem[lastPtr] <= CpuWrData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropCnt  <= '0;
        end else begin
            if (pop)    rdPtr <= rdPtr + PtrW'(1);
            if (pushOk) wrPtr <= wrPtr + PtrW'(1);
            count <= count + CntW'(pushOk) - CntW'(pop);
            // A drop in the clearing cycle still gets recorded.
            if (drop) begin
                overflow <= 1'b1;
                if (ClrOverflow)   dropCnt <= DROP_W'(1);
                else if (~&dropCnt) dropCnt <= dropCnt + DROP_W'(1);
            end else if (ClrOverflow) begin
                overflow <= 1'b0;
                dropCnt  <= '0;
            end
        end
    end

endmodule

// File: doc/screen_wr_buffer.md
Name: screen_wr_buffer

Overview:
- Sits directly downstream of the cpu core and consumes its mirrored memory-write stream (write_m / data_addr / out_m).
- Keeps only writes that land in the screen window.
- Merges back-to-back writes to the same word.
- Buffers the surviving writes in a small FIFO, then drains them one per handshake into the video RAM port read by the VGA scanner. This decouples the single-cycle CPU write from the VGA-side RAM arbitration.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
DATA_W, 16, data word width
ADDR_W, 15, CPU data address width
SCREEN_BASE, 15'h4000, first screen word address
SCREEN_AW, 13, screen window address bits; window = SCREEN_BASE .. SCREEN_BASE + 2**SCREEN_AW - 1
DROP_W, 8, width of drop counter

Ports:
Clock  in  1  single clock for the block
Reset  in  1  synchronous, active-high reset
CpuWrEn  in  1  CPU write strobe (write_m)
CpuWrAddr  in  ADDR_W  CPU write address (data_addr)
CpuWrData  in  DATA_W  CPU write data (out_m)
VramWrEn  out  1  head entry valid / write request to video RAM
VramAddr  out  SCREEN_AW  screen-relative word address of head entry
VramData  out  DATA_W  data of head entry
VramReady  in  1  video RAM accepts the write this cycle
Count  out  $clog2(DEPTH)+1  current occupancy
Full  out  1  Count == DEPTH
Overflow  out  1  sticky flag: at least one write was dropped
DropCnt  out  DROP_W  saturating count of dropped writes
ClrOverflow  in  1  clears Overflow and DropCnt

Behaviour:
- Reset (synchronous, Clock edge with Reset=1):
  - read and write pointers = 0, Count = 0, VramWrEn = 0, Overflow = 0, DropCnt = 0.
  - Storage contents are don't-care.
  - Reset mid-drain discards all pending entries; nothing further is presented.
- Filter:
  - in_window = CpuWrEn && CpuWrAddr >= SCREEN_BASE && CpuWrAddr < SCREEN_BASE + 2**SCREEN_AW.
  - Stored address = CpuWrAddr - SCREEN_BASE, truncated to SCREEN_AW.
  - Out-of-window writes are ignored with no side effects.
- Pop: pop = VramWrEn && VramReady. Head advances on that edge.
- Outputs:
  - VramWrEn = (Count != 0).
  - VramAddr and VramData come from registered storage at the read pointer.
  - They stay stable while VramWrEn=1 and VramReady=0.
- Latency: a push at edge N into an empty FIFO gives VramWrEn=1 with its data from cycle N+1.
- Merge:
  - Applies when in_window, Count != 0, the newest entry's address equals the incoming address, and the newest entry is not being popped this cycle (i.e. not (Count==1 && pop)).
  - Action: overwrite the newest entry's data in place. Count is unchanged and no drop occurs.
  - Merge with Full=1 is allowed.
- Push: in_window and no merge.
  - If Count < DEPTH or pop: write at the write pointer, write pointer +1 (wraps modulo DEPTH).
  - Else (full, no pop): drop the write, set Overflow=1, DropCnt +1 saturating at all-ones.
- Count next = Count + push_accepted - pop. Simultaneous push and pop leave Count unchanged.
- ClrOverflow:
  - clears Overflow and DropCnt on the edge.
  - If a drop occurs in the same cycle, the drop wins: Overflow=1, DropCnt=1.
- Pointers wrap modulo DEPTH. Empty/full are distinguished by Count, not pointer equality.
- Ordering: entries drain strictly in acceptance order. A merge keeps the entry's original position.

Test Plan:
- Reset, then CpuWrEn=1, CpuWrAddr=15'h4005, CpuWrData=16'hBEEF, VramReady=1 -> next cycle VramWrEn=1, VramAddr=5, VramData=BEEF; following cycle Count=0, VramWrEn=0.
- Writes to 15'h3FFF and 15'h6000 -> Count stays 0, no VramWrEn; write to 15'h5FFF -> VramAddr=13'h1FFF.
- VramReady=0, writes to 4010 (data 1), then 4010 (data 2), then 4011 (data 3) -> Count=2. Raise VramReady -> drains (0x10, 2), then (0x11, 3).
- VramReady=0, 18 distinct in-window writes -> Count=16, Full=1, Overflow=1, DropCnt=2. Raise VramReady -> the 16 oldest drain in order. Pulse ClrOverflow -> Overflow=0, DropCnt=0.
- Full FIFO with VramReady=1 and a new distinct write in the same cycle -> accepted, Count stays 16, no drop. Count==1 with that entry popping and a same-address write -> pushed as a new entry (no merge), Count=1 afterwards.
- Reset asserted while Count=5 and draining -> next cycle VramWrEn=0, Count=0. Subsequent write to 4000 appears with VramAddr=0.
